// File: rtl/ili_rst_pkg.sv
// ili_rst_pkg: shared FSM state codes, register addresses and CTRL bit indices for ili_reset_seq.
package ili_rst_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_LOW    = 2'd2;
    localparam logic [1:0] ADDR_WAIT   = 2'd3;
    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;
endpackage

// File: rtl/ili_rst_timer.sv
// ili_rst_timer: loadable down-counter (clk, reset, load, load_val, en -> last when count==1); a load of 0 is clamped to 1.
module ili_rst_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             last
);
    logic [CNT_W-1:0] count_q, count_d;
    always_comb begin
        count_d = load ? ((load_val == '0) ? CNT_W'(1) : load_val)
                : (en && count_q != '0) ? count_q - CNT_W'(1) : count_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
    assign last = count_q == CNT_W'(1);
endmodule

// File: rtl/ili_reset_seq.sv
// ili_reset_seq: Avalon-MM panel reset sequencer (clk, reset, address/chipselect/write_n/writedata/readdata bus; lcd_rst_n, ready, irq); ILI_RST_AUTOSTART_EN starts a sequence out of reset.
module ili_reset_seq
    import ili_rst_pkg::*;
#(
    parameter int CNT_W    = 24,
    parameter int DEF_LOW  = 500,
    parameter int DEF_WAIT = 6000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        lcd_rst_n,
    output logic        ready,
    output logic        irq
);
`ifdef ILI_RST_AUTOSTART_EN
    localparam logic AUTOSTART = 1'b1;
`else
    localparam logic AUTOSTART = 1'b0;
`endif
    state_e           state_q;
    logic [CNT_W-1:0] low_q, wait_q, tmr_val;
    logic             irq_en_q, start_q, abort_q, done_q, lcd_rst_n_q, ready_q;
    logic             we, ctrl_we, busy, go, tmr_load, tmr_last;
    logic             unused_wd;
    assign unused_wd = ^writedata;
    assign we      = chipselect && !write_n;
    assign ctrl_we = we && address == ADDR_CTRL;
    // START/ABORT are latched as one-cycle strobes and acted on at the following edge,
    // so a pending start while forced out of reset behaves exactly like a bus write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q  <= AUTOSTART;
            abort_q  <= 1'b0;
            irq_en_q <= 1'b0;
            low_q    <= CNT_W'(DEF_LOW);
            wait_q   <= CNT_W'(DEF_WAIT);
        end else begin
            start_q  <= ctrl_we && writedata[CTRL_START];
            abort_q  <= ctrl_we && writedata[CTRL_ABORT];
            irq_en_q <= ctrl_we ? writedata[CTRL_IRQ_EN] : irq_en_q;
            low_q    <= (we && address == ADDR_LOW)  ? writedata[CNT_W-1:0] : low_q;
            wait_q   <= (we && address == ADDR_WAIT) ? writedata[CNT_W-1:0] : wait_q;
        end
    end
    always_comb begin
        busy     = state_q == ST_ASSERT || state_q == ST_SETTLE;
        go       = start_q && !abort_q && !busy;
        tmr_load = go || (!abort_q && state_q == ST_ASSERT && tmr_last);
        tmr_val  = go ? low_q : wait_q;
    end
    ili_rst_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (busy),
        .last     (tmr_last)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            lcd_rst_n_q <= 1'b1;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort_q) begin
            state_q     <= ST_IDLE;
            lcd_rst_n_q <= 1'b1;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
        end else if (go) begin
            state_q     <= ST_ASSERT;
            lcd_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
        end else if (state_q == ST_ASSERT && tmr_last) begin
            state_q     <= ST_SETTLE;
            lcd_rst_n_q <= 1'b1;
        end else if (state_q == ST_SETTLE && tmr_last) begin
            state_q     <= ST_DONE;
            ready_q     <= 1'b1;
            done_q      <= 1'b1;
        end
    end
    assign lcd_rst_n = lcd_rst_n_q;
    assign ready     = ready_q;
    assign irq       = done_q & irq_en_q;
    always_comb begin
        readdata = (address == ADDR_CTRL)   ? {29'b0, irq_en_q, 2'b0}
                 : (address == ADDR_STATUS) ? {28'b0, state_q, done_q, busy}
                 : (address == ADDR_LOW)    ? 32'(low_q)
                 :                            32'(wait_q);
    end
endmodule

// File: tb/tb_ili_reset_seq.sv
// tb_ili_reset_seq: scoreboard bench for ili_reset_seq; reads queue expected readdata and pin levels, a negedge monitor compares.
module tb_ili_reset_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        lcd_rst_n, ready, irq;
`ifdef ILI_RST_AUTOSTART_EN
    localparam logic AS = 1'b1;
`else
    localparam logic AS = 1'b0;
`endif
    ili_reset_seq dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .lcd_rst_n  (lcd_rst_n),
        .ready      (ready),
        .irq        (irq)
    );
    always #5 clk = ~clk;
    typedef struct {
        string       name;
        logic [31:0] rd;
        logic [2:0]  pins;
    } exp_t;
    exp_t q[$];
    exp_t m;
    int   n_cmp = 0;
    int   n_bad = 0;
    // Every bus read is an observation point: readdata plus {lcd_rst_n, ready, irq}.
    always @(negedge clk) begin
        if (chipselect && write_n) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read addr=%0d got=%h required=nothing queued", address, readdata);
            end else begin
                m = q.pop_front();
                n_cmp += 2;
                if (readdata !== m.rd) begin
                    n_bad++;
                    $display("FAIL %s readdata got=%h required=%h", m.name, readdata, m.rd);
                end
                if ({lcd_rst_n, ready, irq} !== m.pins) begin
                    n_bad++;
                    $display("FAIL %s pins{rst_n,ready,irq} got=%b required=%b", m.name, {lcd_rst_n, ready, irq}, m.pins);
                end
            end
        end
    end
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask
    task automatic rd(input string n, input logic [1:0] a, input logic [31:0] e, input logic [2:0] p);
        q.push_back('{name: n, rd: e, pins: p});
        address = a;
        chipselect = 1'b1;
        write_n = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
    endtask
    // Expected {STATUS, pins} k edges after the START-sampling edge, irq_en assumed set.
    function automatic logic [34:0] model(int k, int l, int w, logic [31:0] ps, logic [2:0] pp);
        int lc = (l < 1) ? 1 : l;
        int wc = (w < 1) ? 1 : w;
        if (k == 0) return {ps, pp};
        if (k <= lc) return {32'd5, 3'b000};
        if (k <= lc + wc) return {32'd9, 3'b100};
        return {32'd14, 3'b111};
    endfunction
    task automatic seq(input string n, input int l, input int w, input logic [31:0] ps, input logic [2:0] pp, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            logic [34:0] v = model(k, l, w, ps, pp);
            rd($sformatf("%s_k%0d", n, k), 2'd1, v[34:3], v[2:0]);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end
    initial begin
        @(posedge clk);
        #1;
        rd("rst_low", 2'd2, 32'd500, 3'b100);
        rd("rst_wait", 2'd3, 32'd6000000, 3'b100);
        rd("rst_ctrl", 2'd0, 32'd0, 3'b100);
        rd("rst_status", 2'd1, 32'd0, 3'b100);
        reset = 1'b0;
        wr(2'd0, 32'd2);
        wr(2'd2, 32'd4);
        wr(2'd3, 32'd6);
        rd("idle_status", 2'd1, 32'd0, 3'b100);
        wr(2'd0, 32'd5);
        seq("basic", 4, 6, 32'd0, 3'b100, 0, 12);
        rd("ctrl_ie", 2'd0, 32'd4, 3'b111);
        wr(2'd2, 32'd0);
        wr(2'd3, 32'd0);
        wr(2'd0, 32'd5);
        seq("clamp", 0, 0, 32'd14, 3'b111, 0, 4);
        rd("low_zero", 2'd2, 32'd0, 3'b111);
        wr(2'd2, 32'd10);
        wr(2'd0, 32'd5);
        seq("mid_a", 10, 0, 32'd14, 3'b111, 0, 2);
        wr(2'd2, 32'd2);
        wr(2'd0, 32'd5);
        seq("mid_b", 10, 0, 32'd14, 3'b111, 5, 13);
        rd("low_two", 2'd2, 32'd2, 3'b111);
        wr(2'd0, 32'd5);
        seq("mid_c", 2, 0, 32'd14, 3'b111, 0, 4);
        wr(2'd0, 32'd7);
        rd("abort_a_pend", 2'd1, 32'd14, 3'b111);
        rd("abort_a_idle", 2'd1, 32'd0, 3'b100);
        rd("abort_a_ctrl", 2'd0, 32'd4, 3'b100);
        wr(2'd3, 32'd20);
        wr(2'd0, 32'd5);
        seq("abort_b", 2, 20, 32'd0, 3'b100, 0, 4);
        wr(2'd0, 32'd7);
        rd("abort_b_pend", 2'd1, 32'd9, 3'b100);
        rd("abort_b_idle", 2'd1, 32'd0, 3'b100);
        wr(2'd2, 32'd10);
        wr(2'd0, 32'd5);
        seq("rst_run", 10, 20, 32'd0, 3'b100, 0, 2);
        #1;
        reset = 1'b1;
        rd("rst_async", 2'd1, 32'd0, 3'b100);
        rd("rst2_low", 2'd2, 32'd500, 3'b100);
        rd("rst2_wait", 2'd3, 32'd6000000, 3'b100);
        rd("rst2_ctrl", 2'd0, 32'd0, 3'b100);
        reset = 1'b0;
        rd("post_rel_1", 2'd1, AS ? 32'd5 : 32'd0, AS ? 3'b000 : 3'b100);
        rd("post_rel_2", 2'd1, AS ? 32'd5 : 32'd0, AS ? 3'b000 : 3'b100);
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d required=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
